// File: rtl/shared_res_arbiter_pkg.sv
// Shared types and helpers for the shared-resource arbiter and its round-robin picker.
package shared_res_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT   = 2'd1,
        RELEASE = 2'd2
    } state_e;

    localparam int CNT_W   = 8;
    localparam int MAX_REQ = 16;

    function automatic int onehot_to_idx(input logic [MAX_REQ-1:0] oh);
        int idx;
        idx = 0;
        for (int i = 0; i < MAX_REQ; i++) begin
            if (oh[i]) idx = i;
        end
        return idx;
    endfunction

endpackage

// File: rtl/shared_res_arbiter_rr_pick.sv
// Combinational rotate-priority encoder: first set request at or after ptr, wrapping.
module rr_pick
    import shared_res_arbiter_pkg::*;
#(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] ptr_i,
    output logic          found_o,
    output logic [IW-1:0] idx_o
);

    int          pos;
    logic [IW-1:0] sel;
    logic        found;

    always_comb begin
        found = 1'b0;
        idx_o = '0;
        pos   = 0;
        sel   = '0;
        for (int i = 0; i < N; i++) begin
            pos = (int'(ptr_i) + i) % N;
            sel = pos[IW-1:0];
            if (!found && req_i[sel]) begin
                found = 1'b1;
                idx_o = sel;
            end
        end
        found_o = found;
    end

endmodule

// File: rtl/shared_res_arbiter.sv
// Round-robin arbiter sharing one resource: grant, hold until done/abort/timeout, one release cycle.
module shared_res_arbiter
    import shared_res_arbiter_pkg::*;
#(
    parameter  int NUM_REQ = 4,
    parameter  int TIMEOUT = 15,
    localparam int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic               main_clk_i,
    input  logic               main_rst_an_i,
    input  logic               en_i,
    input  logic [NUM_REQ-1:0] req_i,
    input  logic               done_i,
    output logic [NUM_REQ-1:0] gnt_o,
    output logic [IDX_W-1:0]   gnt_idx_o,
    output logic               gnt_valid_o,
    output logic               busy_o,
    output logic               timeout_o,
    output logic               abort_o
);

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   ptr_q, ptr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [NUM_REQ-1:0] gnt_q, gnt_d;
    logic [IDX_W-1:0]   gnt_idx_q, gnt_idx_d;
    logic               gnt_valid_q, gnt_valid_d;
    logic               busy_q, busy_d;
    logic               timeout_q, timeout_d;
    logic               abort_q, abort_d;

    logic               pick_found;
    logic [IDX_W-1:0]   pick_idx;
    logic [IDX_W-1:0]   cur_idx;
    logic [IDX_W-1:0]   ptr_after;

    rr_pick #(.N(NUM_REQ), .IW(IDX_W)) u_pick (
        .req_i   (req_i),
        .ptr_i   (ptr_q),
        .found_o (pick_found),
        .idx_o   (pick_idx)
    );

    // The held grant vector is the single source of truth for which requester owns the resource.
    assign cur_idx   = IDX_W'(onehot_to_idx(MAX_REQ'(gnt_q)));
    assign ptr_after = (cur_idx == IDX_W'(NUM_REQ - 1)) ? '0 : cur_idx + 1'b1;

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        cnt_d       = cnt_q;
        gnt_d       = '0;
        gnt_idx_d   = '0;
        gnt_valid_d = 1'b0;
        busy_d      = 1'b0;
        timeout_d   = 1'b0;
        abort_d     = 1'b0;
        case (state_q)
            IDLE: begin
                if (en_i && pick_found) begin
                    state_d     = GRANT;
                    gnt_d       = NUM_REQ'(1) << pick_idx;
                    gnt_idx_d   = pick_idx;
                    gnt_valid_d = 1'b1;
                    busy_d      = 1'b1;
                    cnt_d       = '0;
                end
            end
            GRANT: begin
                if (done_i || !req_i[cur_idx] || (cnt_q == CNT_W'(TIMEOUT - 1))) begin
                    // Exit priority: completion, then withdrawal, then watchdog.
                    state_d   = RELEASE;
                    busy_d    = 1'b1;
                    ptr_d     = ptr_after;
                    abort_d   = !done_i && !req_i[cur_idx];
                    timeout_d = !done_i && req_i[cur_idx];
                end else begin
                    gnt_d       = gnt_q;
                    gnt_idx_d   = gnt_idx_q;
                    gnt_valid_d = 1'b1;
                    busy_d      = 1'b1;
                    cnt_d       = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + 1'b1;
                end
            end
            RELEASE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge main_clk_i or negedge main_rst_an_i) begin
        if (!main_rst_an_i) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            cnt_q       <= '0;
            gnt_q       <= '0;
            gnt_idx_q   <= '0;
            gnt_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            timeout_q   <= 1'b0;
            abort_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            cnt_q       <= cnt_d;
            gnt_q       <= gnt_d;
            gnt_idx_q   <= gnt_idx_d;
            gnt_valid_q <= gnt_valid_d;
            busy_q      <= busy_d;
            timeout_q   <= timeout_d;
            abort_q     <= abort_d;
        end
    end

    assign gnt_o       = gnt_q;
    assign gnt_idx_o   = gnt_idx_q;
    assign gnt_valid_o = gnt_valid_q;
    assign busy_o      = busy_q;
    assign timeout_o   = timeout_q;
    assign abort_o     = abort_q;

endmodule
